// File: rtl/fixed_point_add_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : fixed_point_add_pipe_if
// Brief    : Operand/result stream bundle for the sign-magnitude adder pipe.
// Revision : 1.0 - initial release
// ============================================================================
interface fixed_point_add_pipe_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;
    logic             clr_count;
    logic [CNT_W-1:0] ovf_count;

    modport master (
        output in_valid, in_a, in_b, out_ready, clr_count,
        input  in_ready, out_valid, out_sum, out_ovf, ovf_count
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready, clr_count,
        output in_ready, out_valid, out_sum, out_ovf, ovf_count
    );
endinterface
`default_nettype wire

// File: rtl/fixed_point_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fixed_point_add_pipe
// Brief    : Two-stage valid/ready sign-magnitude adder with overflow counter.
//            Define FXP_SATURATE_EN to clamp overflowed magnitudes (else wrap).
// Revision : 1.0 - initial release
// ============================================================================
module fixed_point_add_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   n_rst,
    fixed_point_add_pipe_if.slave  bus
);
    localparam int c_MAG_W = WIDTH - 1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic               w_s1_adv;
    logic               w_s2_adv;
    logic [c_MAG_W-1:0] w_mag_a;
    logic [c_MAG_W-1:0] w_mag_b;
    logic               w_a_ge_b;
    logic [c_MAG_W-1:0] w_big;
    logic [c_MAG_W-1:0] w_small;
    logic               w_sub;
    logic               w_sign;
    logic [c_MAG_W:0]   w_sum_ext;
    logic [c_MAG_W-1:0] w_diff;
    logic [c_MAG_W-1:0] w_mag_res;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_result;

    logic               r_s1_valid;
    logic [c_MAG_W-1:0] r_s1_big;
    logic [c_MAG_W-1:0] r_s1_small;
    logic               r_s1_sign;
    logic               r_s1_sub;
    logic               r_s2_valid;
    logic [WIDTH-1:0]   r_out_sum;
    logic               r_out_ovf;
    logic [CNT_W-1:0]   r_ovf_count;

    assign w_s2_adv = !r_s2_valid || bus.out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    always_comb begin
        w_mag_a  = bus.in_a[c_MAG_W-1:0];
        w_mag_b  = bus.in_b[c_MAG_W-1:0];
        w_a_ge_b = (w_mag_a >= w_mag_b);
        w_big    = w_a_ge_b ? w_mag_a : w_mag_b;
        w_small  = w_a_ge_b ? w_mag_b : w_mag_a;
        w_sub    = bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
        // Equal magnitudes with differing signs give zero, normalised in S2.
        w_sign   = (w_sub && !w_a_ge_b) ? bus.in_b[WIDTH-1] : bus.in_a[WIDTH-1];
    end

    always_comb begin
        w_sum_ext = {1'b0, r_s1_big} + {1'b0, r_s1_small};
        w_diff    = r_s1_big - r_s1_small;
        w_ovf     = !r_s1_sub && w_sum_ext[c_MAG_W];
        w_mag_res = r_s1_sub ? w_diff : w_sum_ext[c_MAG_W-1:0];
`ifdef FXP_SATURATE_EN
        if (w_ovf) begin
            w_mag_res = {c_MAG_W{1'b1}};
        end
`endif
        w_result  = (w_mag_res == '0) ? '0 : {r_s1_sign, w_mag_res};
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_big   <= '0;
            r_s1_small <= '0;
            r_s1_sign  <= 1'b0;
            r_s1_sub   <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_big   <= w_big;
                r_s1_small <= w_small;
                r_s1_sign  <= w_sign;
                r_s1_sub   <= w_sub;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_s2_valid <= 1'b0;
            r_out_sum  <= '0;
            r_out_ovf  <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_sum <= w_result;
                r_out_ovf <= w_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst || bus.clr_count) begin
            r_ovf_count <= '0;
        end else if (r_s2_valid && bus.out_ready && r_out_ovf &&
                     (r_ovf_count != {CNT_W{1'b1}})) begin
            r_ovf_count <= r_ovf_count + c_CNT_ONE;
        end
    end

    assign bus.in_ready  = w_s1_adv;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_ovf   = r_out_ovf;
    assign bus.ovf_count = r_ovf_count;
endmodule
`default_nettype wire

// File: tb/tb_fixed_point_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixed_point_add_pipe
// Brief    : Scoreboard bench for fixed_point_add_pipe (WIDTH=32; second
//            instance with CNT_W=2 for counter saturation).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_point_add_pipe;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    fixed_point_add_pipe_if #(.WIDTH(32), .CNT_W(8)) bus ();
    fixed_point_add_pipe_if #(.WIDTH(32), .CNT_W(2)) bus2 ();

    fixed_point_add_pipe #(.WIDTH(32), .CNT_W(8)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    fixed_point_add_pipe #(.WIDTH(32), .CNT_W(2)) dut2 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus2.slave)
    );

`ifdef FXP_SATURATE_EN
    localparam logic [31:0] c_OVF_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] c_OVF_NEG = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] c_OVF_POS = 32'h0000_0000;
    localparam logic [31:0] c_OVF_NEG = 32'h0000_0000;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] es, input logic eo);
        int t;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        #1;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at 0 for %h+%h", a, b);
            bus.in_valid = 1'b0;
        end else begin
            exp_q.push_back({eo, es});
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard monitor: pops on every output transfer, checks hold under stall
    initial begin
        logic        held;
        logic [32:0] held_val;
        logic [32:0] e;
        held = 1'b0;
        held_val = '0;
        forever begin
            @(negedge clk);
            #2;
            if (n_rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected none", bus.out_sum);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_sum", 64'(bus.out_sum), 64'(e[31:0]));
                    chk("out_ovf", 64'(bus.out_ovf), 64'(e[32]));
                end
            end
            if (n_rst && bus.out_valid && !bus.out_ready) begin
                if (held) chk("stall_hold", 64'({bus.out_ovf, bus.out_sum}), 64'(held_val));
                held = 1'b1;
                held_val = {bus.out_ovf, bus.out_sum};
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
        bus.out_ready = 1'b1; bus.clr_count = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0;
        bus2.out_ready = 1'b1; bus2.clr_count = 1'b0;

        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_sum", 64'(bus.out_sum), 64'd0);
        chk("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
        chk("rst_ovf_count", 64'(bus.ovf_count), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Basic signs plus latency of the first result
        send(32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0);
        @(negedge clk); #1;
        chk("latency_early", 64'(bus.out_valid), 64'd0);
        @(negedge clk); #1;
        chk("latency_due", 64'(bus.out_valid), 64'd1);
        send(32'h8000_0002, 32'h0000_0001, 32'h8000_0001, 1'b0);
        send(32'h8000_0001, 32'h0000_0002, 32'h0000_0001, 1'b0);
        send(32'h8000_0001, 32'h8000_0001, 32'h8000_0002, 1'b0);

        // Zero normalisation and non-overflow boundaries
        send(32'h8000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0);
        send(32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0);
        send(32'h7FFF_FFFE, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0);
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        drain();

        // Overflow in both directions
        send(32'h7FFF_FFFF, 32'h0000_0001, c_OVF_POS, 1'b1);
        send(32'hFFFF_FFFF, 32'h8000_0001, c_OVF_NEG, 1'b1);
        drain();
        chk("ovf_count_two", 64'(bus.ovf_count), 64'd2);

        // Back-pressure: out_ready low for four cycles while streaming
        fork
            begin
                send(32'h0000_0010, 32'h0000_0005, 32'h0000_0015, 1'b0);
                send(32'h8000_0010, 32'h0000_0005, 32'h8000_000B, 1'b0);
                send(32'h0000_0003, 32'h8000_0007, 32'h8000_0004, 1'b0);
                send(32'h1234_5678, 32'h0000_0001, 32'h1234_5679, 1'b0);
                send(32'h8000_0100, 32'h8000_0200, 32'h8000_0300, 1'b0);
            end
            begin
                @(negedge clk); bus.out_ready = 1'b1;
                @(negedge clk); bus.out_ready = 1'b0;
                @(negedge clk); bus.out_ready = 1'b0;
                #1 chk("bp_in_ready_full", 64'(bus.in_ready), 64'd0);
                @(negedge clk); bus.out_ready = 1'b0;
                #1 chk("bp_in_ready_held", 64'(bus.in_ready), 64'd0);
                @(negedge clk); bus.out_ready = 1'b0;
                @(negedge clk); bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count_kept", 64'(bus.ovf_count), 64'd2);

        // Reset with both stages full and stalled
        bus.out_ready = 1'b0;
        send(32'h7FFF_FFFF, 32'h0000_0001, c_OVF_POS, 1'b1);
        send(32'h0000_0100, 32'h0000_0001, 32'h0000_0101, 1'b0);
        exp_q.delete();
        @(negedge clk); n_rst = 1'b0;
        @(negedge clk); n_rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_ovf_count", 64'(bus.ovf_count), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        send(32'h0000_0004, 32'h0000_0003, 32'h0000_0007, 1'b0);
        drain();

        // Counter saturation and clear priority on the CNT_W=2 instance
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus2.in_valid = 1'b1; bus2.in_a = 32'h7FFF_FFFF; bus2.in_b = 32'h0000_0001;
        end
        @(negedge clk); bus2.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk("cnt2_saturate", 64'(bus2.ovf_count), 64'd3);
        @(negedge clk); bus2.in_valid = 1'b1;
        @(negedge clk); bus2.in_valid = 1'b0;
        @(negedge clk);
        #1 chk("cnt2_ovf_present", 64'({bus2.out_valid, bus2.out_ovf}), 64'd3);
        bus2.clr_count = 1'b1;
        @(negedge clk); bus2.clr_count = 1'b0;
        #1 chk("cnt2_clr_priority", 64'(bus2.ovf_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
